// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pe_pkg
// Brief  : Shared constants and types for the PE array partial-sum datapath.
// Rev    : 1.0  initial release
// ============================================================================
package pe_pkg;

    localparam int LANES = 7;
    localparam int DW    = 16;
    localparam int CH_W  = 10;
    localparam int AW    = DW + (CH_W - 1) + 1;

    typedef logic signed [DW-1:0] lane_t;
    typedef lane_t [LANES-1:0]    row_t;
    typedef logic signed [AW-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } acc_state_e;

    function automatic acc_t sext_lane(input lane_t v);
        return {{(AW-DW){v[DW-1]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_post.sv
`default_nettype none
// ============================================================================
// Module : psum_post
// Brief  : Per-lane post-processing: bias add, optional ReLU, saturate to DW.
// Rev    : 1.0  initial release
// ============================================================================
module psum_post
    import pe_pkg::*;
(
    input  acc_t  i_acc,
    input  lane_t i_bias,
    input  logic  i_relu,
    output lane_t o_result
);

    localparam acc_t c_max = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam acc_t c_min = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    acc_t w_sum;
    acc_t w_rect;

    // The accumulator is sized so that the bias add can never wrap.
    always_comb begin
        w_sum  = i_acc + sext_lane(i_bias);
        w_rect = (i_relu && w_sum[AW-1]) ? '0 : w_sum;
        if (w_rect > c_max)
            o_result = c_max[DW-1:0];
        else if (w_rect < c_min)
            o_result = c_min[DW-1:0];
        else
            o_result = w_rect[DW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module : psum_accumulator
// Brief  : Accumulates per-channel partial-sum rows, then biases, rectifies,
//          saturates and hands one finished row downstream over valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
module psum_accumulator
    import pe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [CH_W-1:0]       cfg_num_ch,
    input  logic [DW-1:0]         cfg_bias,
    input  logic                  cfg_relu,
    input  logic                  in_valid,
    input  logic [LANES*DW-1:0]   in_psum,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [LANES*DW-1:0]   out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CH_W-1:0] c_one = CH_W'(1);

    acc_state_e      r_state;
    logic [CH_W-1:0] r_num_ch;
    logic [CH_W-1:0] r_count;
    lane_t           r_bias;
    logic            r_relu;
    acc_t            r_acc [LANES];
    logic            r_in_ready;
    logic            r_out_valid;
    row_t            r_out_data;
    logic            r_done;

    acc_t            w_acc_next [LANES];
    lane_t           w_post     [LANES];
    logic            w_accept;
    logic            w_last;

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_count == (r_num_ch - c_one));

    // Post-processing sees the sum including the beat being accepted, so the
    // finished row can be registered on the same edge as the last beat.
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_acc_next[k] = r_acc[k] + sext_lane(in_psum[k*DW +: DW]);

            psum_post u_post (
                .i_acc    (w_acc_next[k]),
                .i_bias   (r_bias),
                .i_relu   (r_relu),
                .o_result (w_post[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_num_ch    <= '0;
            r_count     <= '0;
            r_bias      <= '0;
            r_relu      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
            for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_num_ch   <= (cfg_num_ch == '0) ? c_one : cfg_num_ch;
                        r_bias     <= cfg_bias;
                        r_relu     <= cfg_relu;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= ACCUM;
                        for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_count <= r_count + c_one;
                        for (int k = 0; k < LANES; k++) r_acc[k] <= w_acc_next[k];
                        if (w_last) begin
                            for (int k = 0; k < LANES; k++) r_out_data[k] <= w_post[k];
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire
